// File: rtl/seg_poly_eval_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_poly_eval_pkg
// Purpose  : Shared types, default widths and the saturation helper for the
//            segmented-polynomial evaluator family.
// Revision : 1.0 - initial release
// ============================================================================
package seg_poly_eval_pkg;

   // Default operand/result widths used by the evaluator and its variants
   localparam int DEF_IN_W   = 15;
   localparam int DEF_SEG_W  = 7;
   localparam int DEF_COEF_W = 18;
   localparam int DEF_OUT_W  = 16;

   // Evaluation sequencer states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_LOAD = 3'd2,
      ST_MAC  = 3'd3,
      ST_OUT  = 3'd4
   } state_t;

   // Clamp a wide signed value into the signed range of a w-bit word.
   // The caller truncates the return value to w bits.
   function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                       input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      else
         return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg_poly_eval_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_poly_eval_if
// Purpose  : Operand handshake and result bus of the polynomial evaluator.
//            master = upstream producer / downstream consumer side,
//            slave  = the evaluator itself.
// Revision : 1.0 - initial release
// ============================================================================
interface seg_poly_eval_if #(
   parameter int IN_W  = 15,
   parameter int SEG_W = 7,
   parameter int OUT_W = 16
) ();
   logic                    in_valid;
   logic                    in_ready;
   logic [IN_W-1:0]         dataa;
   logic [SEG_W-1:0]        segment;
   logic signed [OUT_W-1:0] result;
   logic                    done;
   logic                    busy;

   modport master (
      output in_valid, dataa, segment,
      input  in_ready, result, done, busy
   );

   modport slave (
      input  in_valid, dataa, segment,
      output in_ready, result, done, busy
   );
endinterface
`default_nettype wire

// File: rtl/seg_poly_eval_sat_mac.sv
`default_nettype none
// ============================================================================
// Module   : seg_poly_eval_sat_mac
// Purpose  : One Horner step: acc * x (x unsigned Q0.IN_W), arithmetic shift
//            back to the coefficient scale, add the next coefficient and
//            saturate to the signed COEF_W range. Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module seg_poly_eval_sat_mac
   import seg_poly_eval_pkg::*;
#(
   parameter int IN_W   = 15,
   parameter int COEF_W = 18
) (
   input  logic signed [COEF_W-1:0] i_acc,
   input  logic [IN_W-1:0]          i_x,
   input  logic signed [COEF_W-1:0] i_coef,
   output logic signed [COEF_W-1:0] o_acc_next
);
   // Full product width: x is widened by one zero bit to stay non-negative
   localparam int P_W = COEF_W + IN_W + 1;

   logic signed [P_W-1:0] w_acc_ext;
   logic signed [P_W-1:0] w_x_ext;
   logic signed [P_W-1:0] w_coef_ext;
   logic signed [P_W-1:0] w_prod;
   logic signed [P_W-1:0] w_sum;
   logic signed [63:0]    w_sum64;

   // Multiply at full width so x = all-ones can never wrap before clamping
   always_comb begin
      w_acc_ext  = {{(P_W-COEF_W){i_acc[COEF_W-1]}}, i_acc};
      w_x_ext    = {{(P_W-IN_W){1'b0}}, i_x};
      w_coef_ext = {{(P_W-COEF_W){i_coef[COEF_W-1]}}, i_coef};
      w_prod     = w_acc_ext * w_x_ext;
      w_sum      = (w_prod >>> IN_W) + w_coef_ext;
      w_sum64    = {{(64-P_W){w_sum[P_W-1]}}, w_sum};
      o_acc_next = COEF_W'(sat_to_width(w_sum64, COEF_W));
   end

endmodule
`default_nettype wire

// File: rtl/seg_poly_eval.sv
`default_nettype none
// ============================================================================
// Module   : seg_poly_eval
// Purpose  : Segmented-polynomial evaluator. Accepts (x, segment), fetches
//            coefficients c_DEGREE..c_0 from a 1-cycle synchronous ROM and
//            evaluates the polynomial by saturating Horner iteration.
// Revision : 1.0 - initial release
// ============================================================================
module seg_poly_eval
   import seg_poly_eval_pkg::*;
#(
   parameter int IN_W      = DEF_IN_W,
   parameter int SEG_W     = DEF_SEG_W,
   parameter int DEGREE    = 2,
   parameter int COEF_W    = DEF_COEF_W,
   parameter int OUT_W     = DEF_OUT_W,
   parameter int OUT_SHIFT = 2,
   parameter int K_W       = $clog2(DEGREE + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   seg_poly_eval_if.slave           bus,
   output logic [SEG_W+K_W-1:0]     coef_addr,
   input  logic signed [COEF_W-1:0] coef_data
);

   state_t                  r_state;
   state_t                  w_next_state;
   logic [K_W-1:0]          r_k;
   logic [K_W-1:0]          w_k_dec;
   logic [IN_W-1:0]         r_x;
   logic [SEG_W-1:0]        r_seg;
   logic signed [COEF_W-1:0] r_acc;
   logic signed [COEF_W-1:0] w_acc_next;
   logic signed [63:0]      w_acc_next64;
   logic signed [OUT_W-1:0] w_res_next;
   logic signed [OUT_W-1:0] r_result;
   logic [SEG_W+K_W-1:0]    r_addr_hold;
   logic [SEG_W+K_W-1:0]    w_addr;
   logic                    w_in_ready;
   logic                    w_done;
   logic                    w_busy;

   seg_poly_eval_sat_mac #(
      .IN_W   (IN_W),
      .COEF_W (COEF_W)
   ) u_sat_mac (
      .i_acc      (r_acc),
      .i_x        (r_x),
      .i_coef     (coef_data),
      .o_acc_next (w_acc_next)
   );

   // Final scaling: shift the last accumulator value and clamp to OUT_W
   always_comb begin
      w_acc_next64 = {{(64-COEF_W){w_acc_next[COEF_W-1]}}, w_acc_next};
      w_res_next   = OUT_W'(sat_to_width(w_acc_next64 >>> OUT_SHIFT, OUT_W));
   end

   // Sequencer state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_next_state;
   end

   // Next state, handshake flags and the ROM address presented this cycle
   always_comb begin
      w_next_state = r_state;
      w_in_ready   = 1'b0;
      w_done       = 1'b0;
      w_busy       = 1'b1;
      w_addr       = r_addr_hold;
      w_k_dec      = (r_k == '0) ? '0 : r_k - K_W'(1);
      case (r_state)
         ST_IDLE: begin
            w_in_ready = 1'b1;
            w_busy     = 1'b0;
            if (bus.in_valid)
               w_next_state = ST_ADDR;
         end
         ST_ADDR: begin
            w_addr       = {r_seg, r_k};
            w_next_state = ST_LOAD;
         end
         ST_LOAD: begin
            w_addr       = {r_seg, r_k};
            w_next_state = ST_MAC;
         end
         ST_MAC: begin
            // Address of the coefficient consumed in the following MAC cycle
            w_addr = {r_seg, w_k_dec};
            if (r_k == '0)
               w_next_state = ST_OUT;
         end
         ST_OUT: begin
            w_done       = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: begin
            w_busy       = 1'b0;
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Operand capture, term counter, Horner accumulator and result register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_k         <= '0;
         r_x         <= '0;
         r_seg       <= '0;
         r_acc       <= '0;
         r_result    <= '0;
         r_addr_hold <= '0;
      end else begin
         // Keeps coef_addr frozen once the sequencer leaves the MAC phase
         r_addr_hold <= w_addr;
         case (r_state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  r_x   <= bus.dataa;
                  r_seg <= bus.segment;
                  r_k   <= K_W'(DEGREE);
               end
            end
            ST_ADDR: r_k <= r_k - K_W'(1);
            ST_LOAD: r_acc <= coef_data;
            ST_MAC: begin
               r_acc <= w_acc_next;
               if (r_k == '0)
                  r_result <= w_res_next;
               else
                  r_k <= r_k - K_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign coef_addr    = w_addr;
   assign bus.in_ready = w_in_ready;
   assign bus.done     = w_done;
   assign bus.busy     = w_busy;
   assign bus.result   = r_result;

endmodule
`default_nettype wire

// File: tb/tb_seg_poly_eval.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_poly_eval
// Purpose  : Self-checking bench for seg_poly_eval with a behavioural ROM and
//            an arithmetic reference model of the saturating Horner result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_poly_eval;
   localparam int IN_W      = 15;
   localparam int SEG_W     = 7;
   localparam int DEGREE    = 2;
   localparam int COEF_W    = 18;
   localparam int OUT_W     = 16;
   localparam int OUT_SHIFT = 2;
   localparam int K_W       = 2;
   localparam int NSLOT     = 1 << (SEG_W + K_W);

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic [SEG_W+K_W-1:0]     coef_addr;
   logic signed [COEF_W-1:0] coef_data = '0;
   logic signed [COEF_W-1:0] rom [NSLOT];

   int checks   = 0;
   int failures = 0;

   seg_poly_eval_if #(.IN_W(IN_W), .SEG_W(SEG_W), .OUT_W(OUT_W)) bus ();

   seg_poly_eval #(
      .IN_W      (IN_W),
      .SEG_W     (SEG_W),
      .DEGREE    (DEGREE),
      .COEF_W    (COEF_W),
      .OUT_W     (OUT_W),
      .OUT_SHIFT (OUT_SHIFT)
   ) dut (
      .clk       (clk),
      .rst       (rst_n),
      .bus       (bus),
      .coef_addr (coef_addr),
      .coef_data (coef_data)
   );

   always #5 clk = ~clk;

   // Synchronous coefficient ROM, data one cycle after the address
   always @(posedge clk) coef_data <= rom[coef_addr];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic longint floor_div(input longint a, input longint d);
      longint q;
      q = a / d;
      if ((a % d) != 0 && a < 0) q = q - 1;
      return q;
   endfunction

   function automatic longint clamp(input longint v, input int w);
      longint hi;
      longint lo;
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -(longint'(1) << (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic longint coef(input int seg, input int k);
      return longint'(rom[seg * (1 << K_W) + k]);
   endfunction

   function automatic longint model_eval(input int seg, input longint x);
      longint acc;
      acc = coef(seg, DEGREE);
      for (int k = DEGREE - 1; k >= 0; k--)
         acc = clamp(floor_div(acc * x, longint'(1) << IN_W) + coef(seg, k), COEF_W);
      return clamp(floor_div(acc, longint'(1) << OUT_SHIFT), OUT_W);
   endfunction

   // Transaction-level tracker: cycles left in the current evaluation
   int     m_cnt  = 0;
   longint m_exp  = 0;
   longint m_last = 0;
   int     m_seg  = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  = 0;
         m_last = 0;
         m_seg  = 0;
      end else if (m_cnt == 0) begin
         if (bus.in_valid) begin
            m_cnt = DEGREE + 3;
            m_exp = model_eval(int'(bus.segment), longint'(bus.dataa));
            m_seg = int'(bus.segment);
         end
      end else begin
         if (m_cnt == 1) m_last = m_exp;
         m_cnt--;
      end
   end

   // Per-cycle compare against the tracker
   always @(negedge clk) begin
      if (rst_n) begin
         check("busy", longint'(bus.busy), longint'(m_cnt != 0));
         check("in_ready", longint'(bus.in_ready), longint'(m_cnt == 0));
         check("done", longint'(bus.done), longint'(m_cnt == 1));
         check("result", longint'(bus.result), (m_cnt == 1) ? m_exp : m_last);
         if (m_cnt <= 1)
            check("coef_addr_hold", longint'(coef_addr), longint'(m_seg) << K_W);
      end
   end

   // ---------------- stimulus ----------------
   task automatic run_directed(input string name, input int seg, input longint c2,
                               input longint c1, input longint c0, input int x,
                               input longint lit);
      int lat;
      rom[seg * 4 + 2] = COEF_W'(c2);
      rom[seg * 4 + 1] = COEF_W'(c1);
      rom[seg * 4 + 0] = COEF_W'(c0);
      check({name, "_model"}, model_eval(seg, longint'(x)), lit);
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.dataa    = IN_W'(x);
      bus.segment  = SEG_W'(seg);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({name, "_latency"}, longint'(lat), longint'(DEGREE + 3));
      check({name, "_result"}, longint'(bus.result), lit);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.dataa    = '0;
      bus.segment  = '0;
      for (int i = 0; i < NSLOT; i++) rom[i] = '0;

      #1 rst_n = 1'b0;
      #2;
      check("rst_done", longint'(bus.done), 0);
      check("rst_busy", longint'(bus.busy), 0);
      check("rst_result", longint'(bus.result), 0);
      check("rst_coef_addr", longint'(coef_addr), 0);
      #19 rst_n = 1'b1;

      run_directed("constant", 1, 0, 0, 1000, 'h4449, 250);
      run_directed("linear", 2, 0, 4096, 0, 'h4000, 512);
      run_directed("sat_pos", 3, 0, 131071, 131071, 'h7FFF, 32767);
      run_directed("sat_neg", 3, 0, -131071, -131071, 'h7FFF, -32768);
      run_directed("neg_trunc", 4, 0, 0, -1001, 'h1234, -251);
      run_directed("x_zero_maxseg", 127, 5000, -7000, 4003, 0, 1000);

      // Back-pressure: valid held high with a new operand every cycle
      @(posedge clk); #1;
      bus.segment = 7'd2;
      for (int i = 0; i < 3 * (DEGREE + 4); i++) begin
         bus.in_valid = 1'b1;
         bus.dataa    = IN_W'($urandom);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      repeat (8) @(posedge clk);

      // Asynchronous reset in the middle of the MAC phase
      #1;
      bus.in_valid = 1'b1;
      bus.dataa    = 15'h4000;
      bus.segment  = 7'd2;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("midrst_done", longint'(bus.done), 0);
      check("midrst_busy", longint'(bus.busy), 0);
      check("midrst_result", longint'(bus.result), 0);
      check("midrst_coef_addr", longint'(coef_addr), 0);
      @(posedge clk); @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("postrst_in_ready", longint'(bus.in_ready), 1);
      run_directed("after_reset", 2, 0, 4096, 0, 'h4000, 512);

      // Randomised phase: mix of small and full-range coefficients
      @(posedge clk); #1;
      for (int i = 0; i < NSLOT; i++) begin
         if ((i >> K_W) % 2 == 0)
            rom[i] = COEF_W'($signed($urandom_range(8192, 0)) - 4096);
         else
            rom[i] = COEF_W'($urandom);
      end
      for (int i = 0; i < 600; i++) begin
         bus.in_valid = ($urandom_range(2, 0) == 0);
         bus.dataa    = ($urandom_range(7, 0) == 0) ? {IN_W{1'b1}} : IN_W'($urandom);
         bus.segment  = SEG_W'($urandom);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
